// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped I/O port block: address map,
// 7-segment patterns, debounce state encoding and the debounce length clamp.
package io_pkg;

    localparam logic [15:0] IO_SW_ADDR   = 16'hfff0;
    localparam logic [15:0] IO_STAT_ADDR = 16'hfff2;
    localparam logic [15:0] IO_SEG_ADDR  = 16'hfffa;
    localparam logic [11:0] IO_BASE      = 12'hfff;

    localparam logic [6:0]  SEG_0        = 7'b1111110;
    localparam logic [6:0]  SEG_2        = 7'b1101101;

    typedef enum logic {
        DB_STABLE = 1'b0,
        DB_COUNT  = 1'b1
    } db_state_e;

    // Debounce lengths below two samples are not meaningful; clamp them.
    function automatic logic [15:0] db_limit(input logic [15:0] cycles);
        logic [15:0] lim;
        if (cycles < 16'd2) begin
            lim = 16'd2;
        end else begin
            lim = cycles;
        end
        return lim;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Single-bit switch debouncer. The input must already be synchronized.
// A change on sync_i is accepted once the counter reaches DB_CYCLES-1
// without the input falling back to the accepted level.
module sw_debounce
    import io_pkg::*;
#(
    parameter logic [15:0] DB_CYCLES = 16'd50000
) (
    input  logic clock,
    input  logic reset,
    input  logic sync_i,
    output logic stable_o,
    output logic accept_o
);

    // Accept on the edge where the counter would step onto DB_CYCLES-1.
    localparam logic [15:0] DB_ACC = db_limit(DB_CYCLES) - 16'd2;

    db_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        stable_q, stable_d;

    // Next-state logic: count consecutive differing samples, restart on a match.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        accept_o = 1'b0;
        case (state_q)
            DB_STABLE: begin
                if (sync_i != stable_q) begin
                    state_d = DB_COUNT;
                    cnt_d   = 16'd1;
                end else begin
                    cnt_d   = 16'd0;
                end
            end
            DB_COUNT: begin
                if (sync_i == stable_q) begin
                    state_d = DB_STABLE;
                    cnt_d   = 16'd0;
                end else if (cnt_q >= DB_ACC) begin
                    // '>=' keeps the counter bounded even for odd parameter values.
                    state_d  = DB_STABLE;
                    cnt_d    = 16'd0;
                    stable_d = sync_i;
                    accept_o = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = DB_STABLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    // State register; reset abandons any pending change.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= DB_STABLE;
            cnt_q    <= 16'd0;
            stable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/io_ports.sv
// Memory-mapped I/O ports: two debounced switches, a change-status flag
// (read-to-clear) and a 7-segment display register.
// Optional feature macro: IO_DEBOUNCE_EN (defined -> per-bit debounce,
// undefined -> switches used straight from the synchronizer).
module io_ports
    import io_pkg::*;
#(
    parameter logic [15:0] DB_CYCLES = 16'd50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] daddr,
    input  logic [15:0] dwdata,
    input  logic        memread,
    input  logic        memwrite,
    output logic [15:0] drdata,
    output logic        io_sel,
    input  logic [1:0]  sw,
    output logic [6:0]  seg
);

    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;
    logic [6:0] seg_q, seg_d;
    logic       chg_flag_q, chg_flag_d;
    logic [1:0] sw_stable;
    logic       sw_changed;
    logic       seg_wr;
    logic       stat_rd;
    logic       unused_dwdata;

    // Upper store bits have no destination in the display register.
    assign unused_dwdata = ^dwdata[15:7];

    // Two-flop synchronizer inputs.
    always_comb begin
        sync1_d = sw;
        sync2_d = sync1_q;
    end

`ifdef IO_DEBOUNCE_EN
    logic [1:0] db_accept;

    sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db0 (
        .clock    (clock),
        .reset    (reset),
        .sync_i   (sync2_q[0]),
        .stable_o (sw_stable[0]),
        .accept_o (db_accept[0])
    );

    sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db1 (
        .clock    (clock),
        .reset    (reset),
        .sync_i   (sync2_q[1]),
        .stable_o (sw_stable[1]),
        .accept_o (db_accept[1])
    );

    assign sw_changed = |db_accept;
`else
    assign sw_stable  = sync2_q;
    assign sw_changed = (sync2_d != sync2_q);

    // DB_CYCLES only matters when the debouncers are built in.
    if (DB_CYCLES == 16'd0) begin : g_db_unused
    end
`endif

    assign seg_wr  = memwrite && (daddr == IO_SEG_ADDR);
    assign stat_rd = memread  && (daddr == IO_STAT_ADDR);

    // Display register and change flag next state; a new change beats a clear.
    always_comb begin
        if (seg_wr) begin
            seg_d = dwdata[6:0];
        end else begin
            seg_d = seg_q;
        end
        if (sw_changed) begin
            chg_flag_d = 1'b1;
        end else if (stat_rd) begin
            chg_flag_d = 1'b0;
        end else begin
            chg_flag_d = chg_flag_q;
        end
    end

    // All block state; reset overrides any concurrent store.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q    <= 2'b00;
            sync2_q    <= 2'b00;
            seg_q      <= 7'b0000000;
            chg_flag_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            seg_q      <= seg_d;
            chg_flag_q <= chg_flag_d;
        end
    end

    // Zero-latency read decode for the I/O window.
    always_comb begin
        io_sel = (daddr[15:4] == IO_BASE);
        drdata = 16'h0000;
        if (memread && io_sel) begin
            case (daddr)
                IO_SW_ADDR:   drdata = {14'b0, sw_stable};
                IO_STAT_ADDR: drdata = {15'b0, chg_flag_q};
                IO_SEG_ADDR:  drdata = {9'b0, seg_q};
                default:      drdata = 16'h0000;
            endcase
        end else begin
            drdata = 16'h0000;
        end
    end

    assign seg = seg_q;

endmodule

// File: tb/tb_io_ports.sv
// Self-checking bench for io_ports: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model.
module tb_io_ports;

    localparam int DB = 8;
`ifdef IO_DEBOUNCE_EN
    localparam int LAT = 9;   // 2 synchronizer cycles + 7 debounce cycles
`else
    localparam int LAT = 2;   // synchronizer only
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] daddr = 16'h0000;
    logic [15:0] dwdata = 16'h0000;
    logic        memread = 1'b0;
    logic        memwrite = 1'b0;
    logic [15:0] drdata;
    logic        io_sel;
    logic [1:0]  sw = 2'b00;
    logic [6:0]  seg;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    logic [1:0] m_s1, m_s2, m_stable;
    int         m_run [2];
    logic       m_flag;
    logic [6:0] m_seg;

    io_ports #(.DB_CYCLES(16'd8)) dut (
        .clock    (clock),
        .reset    (reset),
        .daddr    (daddr),
        .dwdata   (dwdata),
        .memread  (memread),
        .memwrite (memwrite),
        .drdata   (drdata),
        .io_sel   (io_sel),
        .sw       (sw),
        .seg      (seg)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_rd();
        logic [15:0] v;
        v = 16'h0000;
        if (memread && daddr[15:4] == 12'hfff) begin
            if (daddr == 16'hfff0)      v = {14'b0, m_stable};
            else if (daddr == 16'hfff2) v = {15'b0, m_flag};
            else if (daddr == 16'hfffa) v = {9'b0, m_seg};
            else                        v = 16'h0000;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_s1 = 2'b00; m_s2 = 2'b00; m_stable = 2'b00;
        m_run[0] = 0; m_run[1] = 0;
        m_flag = 1'b0; m_seg = 7'd0;
    endtask

    // Advance the model by one rising edge using the inputs just sampled.
    task automatic model_edge();
        logic [1:0] s2_pre, old_stable;
        if (reset) begin
            model_reset();
        end else begin
            s2_pre = m_s2;
            m_s2 = m_s1;
            m_s1 = sw;
            old_stable = m_stable;
`ifdef IO_DEBOUNCE_EN
            // A run of DB-1 consecutive differing synchronized samples flips the bit.
            for (int b = 0; b < 2; b++) begin
                if (s2_pre[b] != m_stable[b]) begin
                    m_run[b]++;
                    if (m_run[b] >= DB - 1) begin
                        m_stable[b] = s2_pre[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
`else
            m_stable = m_s2;
`endif
            if (m_stable != old_stable)
                m_flag = 1'b1;
            else if (memread && daddr == 16'hfff2)
                m_flag = 1'b0;
            if (memwrite && daddr == 16'hfffa)
                m_seg = dwdata[6:0];
        end
    endtask

    // One clock: compare outputs on the falling edge, then step the model.
    task automatic cycle();
        @(negedge clock);
        check("io_sel", io_sel, (daddr[15:4] == 12'hfff));
        check("drdata", drdata, exp_rd());
        check("seg", seg, m_seg);
        @(posedge clock);
        model_edge();
        #1;
    endtask

    // Read the switch port each cycle until bit b shows value v; report latency.
    task automatic measure(input int b, input logic v, input string tag);
        int seen;
        seen = -1;
        memread = 1'b1; memwrite = 1'b0; daddr = 16'hfff0;
        for (int k = 1; k <= 30 && seen < 0; k++) begin
            cycle();
            #1;
            if (drdata[b] === v) seen = k;
        end
        check(tag, seen, LAT);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state and address decode
        memread = 1'b1; daddr = 16'hfff0; #1;
        check("rst_rd_sw", drdata, 16'h0000);
        check("io_sel_fff0", io_sel, 1'b1);
        check("rst_seg", seg, 7'b0000000);
        cycle();
        daddr = 16'hfffa; #1;
        check("rst_rd_seg", drdata, 16'h0000);
        cycle();
        daddr = 16'h0010; #1;
        check("io_sel_0010", io_sel, 1'b0);
        cycle();

        // Display store, read-back, ignored store to the switch port
        memread = 1'b0; memwrite = 1'b1; daddr = 16'hfffa; dwdata = 16'hff6d;
        cycle();
        memwrite = 1'b0; #1;
        check("seg_store", seg, 7'b1101101);
        memread = 1'b1; #1;
        check("rd_seg", drdata, 16'h006d);
        cycle();
        memread = 1'b0; memwrite = 1'b1; daddr = 16'hfff0; dwdata = 16'hffff;
        cycle();
        memwrite = 1'b0; #1;
        check("seg_kept", seg, 7'b1101101);
        memread = 1'b1; #1;
        check("rd_sw_kept", drdata, 16'h0000);
        cycle();
        // Simultaneous load and store: read sees the old value, store lands
        memread = 1'b1; memwrite = 1'b1; daddr = 16'hfffa; dwdata = 16'h007e; #1;
        check("rw_old", drdata, 16'h006d);
        cycle();
        memwrite = 1'b0; #1;
        check("rw_new", drdata, 16'h007e);
        cycle();

        // Switch acceptance latency
        sw = 2'b01;
        measure(0, 1'b1, "sw0_rise_lat");
        memread = 1'b1; daddr = 16'hfff2; #1;
        check("chg_set", drdata, 16'h0001);
        cycle();
        #1;
        check("chg_clr", drdata, 16'h0000);
        cycle();

        // Bounce: short low pulse must not be accepted
        memread = 1'b0;
        sw = 2'b00; repeat (5) cycle();
        sw = 2'b01; repeat (3) cycle();
        memread = 1'b1; daddr = 16'hfff0; #1;
        check("bounce_hold", drdata, 16'h0001);
        sw = 2'b00;
        measure(0, 1'b0, "sw0_fall_lat");

        // Accept coincident with a status read: flag stays set
        memread = 1'b0;
        sw = 2'b10;
        repeat (LAT - 1) cycle();
        memread = 1'b1; daddr = 16'hfff2; #1;
        check("stat_coinc_rd", drdata, 16'h0001);
        cycle();
        #1;
        check("stat_set_wins", drdata, 16'h0001);
        cycle();
        #1;
        check("stat_cleared", drdata, 16'h0000);
        daddr = 16'hfff0; #1;
        check("sw1_accept", drdata, 16'h0002);
        cycle();

        // Reset mid-debounce and during a store
        memread = 1'b0;
        sw = 2'b00; repeat (LAT + 2) cycle();
        sw = 2'b10; repeat (4) cycle();
        reset = 1'b1; memwrite = 1'b1; daddr = 16'hfffa; dwdata = 16'h007f;
        cycle();
        reset = 1'b0; memwrite = 1'b0; #1;
        check("rst_seg_store", seg, 7'b0000000);
        memread = 1'b1; daddr = 16'hfff0; #1;
        check("rst_sw_clear", drdata, 16'h0000);
        measure(1, 1'b1, "sw1_after_rst_lat");

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) sw = 2'($urandom);
            reset    = ($urandom_range(0, 79) == 0);
            memread  = 1'($urandom_range(0, 1));
            memwrite = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0: daddr = 16'hfff0;
                1: daddr = 16'hfff2;
                2: daddr = 16'hfffa;
                3: daddr = 16'hfff4;
                4: daddr = 16'h0010;
                default: daddr = 16'($urandom);
            endcase
            dwdata = 16'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
